// File: rtl/ext_response_checker_pkg.sv
// Shared types and defaults for the ext-module response checker.
// FSM states and lane identifiers used by the checker top.
package ext_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE1     = 2'b01;
  localparam logic [1:0] LANE2     = 2'b10;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/ext_response_checker_if.sv
// Stimulus/response bundle between the ext-module tester and the checker.
// master = tester side, slave = checker side.
interface ext_response_checker_if
  import ext_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic [WIDTH-1:0] bar1;
  logic             bar1_valid;
  logic [WIDTH-1:0] bar2;
  logic             bar2_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] mism1_cnt;
  logic [CNT_W-1:0] mism2_cnt;
  logic [WIDTH-1:0] first_bad;
  logic [1:0]       first_bad_lane;

  modport master (
    output start, bar1, bar1_valid, bar2, bar2_valid,
    input  busy, done, pass, timeout,
    input  mism1_cnt, mism2_cnt, first_bad, first_bad_lane
  );

  modport slave (
    input  start, bar1, bar1_valid, bar2, bar2_valid,
    output busy, done, pass, timeout,
    output mism1_cnt, mism2_cnt, first_bad, first_bad_lane
  );
endinterface

// File: rtl/ext_resp_lane.sv
// One response lane: sample counter, saturating mismatch counter,
// combinational mismatch/last-sample strobes for the top's verdict.
module ext_resp_lane
  import ext_checker_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] EXP         = 16'h03E8,
  parameter int               NUM_SAMPLES = 8,
  parameter int               CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             mism,
  output logic             last,
  output logic             lane_done
);
  localparam int SC_W = $clog2(NUM_SAMPLES + 1);

  logic [SC_W-1:0] smp_cnt;
  logic            take;

  assign lane_done = (smp_cnt == SC_W'(NUM_SAMPLES));
  assign take      = en & valid & ~lane_done;
  assign mism      = take & (data != EXP);
  assign last      = take & (smp_cnt == SC_W'(NUM_SAMPLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      smp_cnt  <= '0;
      mism_cnt <= '0;
    end else if (clr) begin
      smp_cnt  <= '0;
      mism_cnt <= '0;
    end else if (take) begin
      smp_cnt <= smp_cnt + 1'b1;
      if (mism && mism_cnt != '1)
        mism_cnt <= mism_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ext_response_checker.sv
// Checks two ext-module bar lanes against expected values and
// reports a registered verdict, mismatch counts and the first bad sample.
module ext_response_checker
  import ext_checker_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] EXP1        = 16'h03E8,
  parameter logic [WIDTH-1:0] EXP2        = 16'h03E8,
  parameter int               NUM_SAMPLES = 8,
  parameter int               TIMEOUT     = 256,
  parameter int               CNT_W       = DEF_CNT_W
) (
  input logic                   clock,
  input logic                   reset,
  ext_response_checker_if.slave bus
);
  localparam int CYC_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CYC_W-1:0] cyc;
  logic             busy_q, done_q, pass_q, tmo_q;
  logic [WIDTH-1:0] fb_q;
  logic [1:0]       fb_lane_q;

  logic             clr, en;
  logic [CNT_W-1:0] m1_cnt, m2_cnt;
  logic             m1, m2, last1, last2, dn1, dn2;
  logic             fin1, fin2;

  assign en   = (state == CHECK);
  assign clr  = bus.start & (state != CHECK);
  assign fin1 = dn1 | last1;
  assign fin2 = dn2 | last2;

  ext_resp_lane #(
    .WIDTH(WIDTH), .EXP(EXP1),
    .NUM_SAMPLES(NUM_SAMPLES), .CNT_W(CNT_W)
  ) u_lane1 (
    .clock(clock), .reset(reset), .clr(clr), .en(en),
    .valid(bus.bar1_valid), .data(bus.bar1),
    .mism_cnt(m1_cnt), .mism(m1), .last(last1), .lane_done(dn1)
  );

  ext_resp_lane #(
    .WIDTH(WIDTH), .EXP(EXP2),
    .NUM_SAMPLES(NUM_SAMPLES), .CNT_W(CNT_W)
  ) u_lane2 (
    .clock(clock), .reset(reset), .clr(clr), .en(en),
    .valid(bus.bar2_valid), .data(bus.bar2),
    .mism_cnt(m2_cnt), .mism(m2), .last(last2), .lane_done(dn2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      tmo_q     <= 1'b0;
      fb_q      <= '0;
      fb_lane_q <= LANE_NONE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= CHECK;
            cyc       <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            tmo_q     <= 1'b0;
            fb_q      <= '0;
            fb_lane_q <= LANE_NONE;
          end
        end
        CHECK: begin
          cyc <= cyc + 1'b1;
          // lane 1 wins when both lanes miss on the same cycle
          if (fb_lane_q == LANE_NONE) begin
            if (m1) begin
              fb_q      <= bus.bar1;
              fb_lane_q <= LANE1;
            end else if (m2) begin
              fb_q      <= bus.bar2;
              fb_lane_q <= LANE2;
            end
          end
          // completion takes precedence over a coincident timeout
          if (fin1 && fin2) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (m1_cnt == '0) & ~m1 &
                      (m2_cnt == '0) & ~m2;
          end else if (cyc == CYC_W'(TIMEOUT - 1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            tmo_q  <= 1'b1;
            pass_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.timeout        = tmo_q;
  assign bus.mism1_cnt      = m1_cnt;
  assign bus.mism2_cnt      = m2_cnt;
  assign bus.first_bad      = fb_q;
  assign bus.first_bad_lane = fb_lane_q;
endmodule
